// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline; the memory arbiter FSM state lives here.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Merges the IF fetch port and the MEM data port onto one physical memory port.
// Data requests win ties because they belong to the older instruction in the pipe.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_byte_enable,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_W-1:0]     pmem_address,
  output logic [DATA_W-1:0]     pmem_wdata,
  output logic [DATA_W/8-1:0]   pmem_byte_enable,
  input  logic [DATA_W-1:0]     pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  arb_state_t next_state;
  logic       is_write;
  logic       dropped;
  logic       d_req;

  assign d_req = d_read | d_write;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req) next_state = D_BUSY;
        else if (i_read) next_state = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A requester that lets go of its request at any point while busy loses its
  // response; the sticky dropped flag remembers that until the transaction ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      is_write         <= 1'b0;
      dropped          <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      i_rdata          <= '0;
      d_rdata          <= '0;
      i_resp           <= 1'b0;
      d_resp           <= 1'b0;
    end else begin
      state  <= next_state;
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          dropped <= 1'b0;
          if (d_req) begin
            pmem_address     <= d_addr;
            pmem_wdata       <= d_wdata;
            pmem_byte_enable <= d_byte_enable;
            is_write         <= d_write;
            pmem_read        <= d_read;
            pmem_write       <= d_write;
          end else if (i_read) begin
            pmem_address <= i_addr;
            is_write     <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        I_BUSY: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            if (i_read && !dropped) begin
              i_rdata <= pmem_rdata;
              i_resp  <= 1'b1;
            end
          end else if (!i_read) begin
            dropped <= 1'b1;
          end
        end
        D_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (d_req && !dropped) begin
              d_resp <= 1'b1;
              if (!is_write) d_rdata <= pmem_rdata;
            end
          end else if (!d_req) begin
            dropped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_byte_enable;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic [3:0]        pmem_byte_enable;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int check_count = 0;
  int pass_count  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b1; i_addr = 32'h60;
    tick(); tick();
    check_count++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
      $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
    else pass_count++;
    check_count++;
    if ({pmem_address, pmem_wdata, pmem_byte_enable} !== '0)
      $display("FAIL reset_pmem_fields: got addr %h wdata %h be %b want 0", pmem_address, pmem_wdata, pmem_byte_enable);
    else pass_count++;
    check_count++;
    if ({i_rdata, d_rdata} !== '0)
      $display("FAIL reset_rdata: got i %h d %h want 0", i_rdata, d_rdata);
    else pass_count++;
    rst = 1'b0;
    tick();
    check_count++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h60)
      $display("FAIL reset_release_grant: got read %b addr %h want 1 00000060", pmem_read, pmem_address);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'h11;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (i_resp !== 1'b1 || i_rdata !== 32'h11)
      $display("FAIL reset_release_resp: got resp %b data %h want 1 00000011", i_resp, i_rdata);
    else pass_count++;
    i_read = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    i_read = 1'b1; i_addr = 32'h100;
    tick();
    check_count++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h100)
      $display("FAIL fetch_issue: got read %b write %b addr %h want 1 0 00000100", pmem_read, pmem_write, pmem_address);
    else pass_count++;
    tick(); tick();
    check_count++;
    if (pmem_read !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL fetch_hold: got read %b resp %b want 1 0", pmem_read, i_resp);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'h00000013;
    tick();
    pmem_resp = 1'b0; pmem_rdata = 32'hFFFFFFFF;
    check_count++;
    if (i_resp !== 1'b1 || i_rdata !== 32'h00000013 || pmem_read !== 1'b0)
      $display("FAIL fetch_resp: got resp %b data %h read %b want 1 00000013 0", i_resp, i_rdata, pmem_read);
    else pass_count++;
    i_read = 1'b0;
    tick();
    check_count++;
    if (i_resp !== 1'b0 || i_rdata !== 32'h00000013)
      $display("FAIL fetch_pulse_end: got resp %b data %h want 0 00000013", i_resp, i_rdata);
    else pass_count++;
  endtask

  task automatic test_conflict();
    i_read = 1'b1; i_addr = 32'h104;
    d_read = 1'b1; d_addr = 32'h2000;
    tick();
    check_count++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h2000)
      $display("FAIL conflict_data_first: got read %b addr %h want 1 00002000", pmem_read, pmem_address);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAA5555;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== 32'hAAAA5555)
      $display("FAIL conflict_d_resp: got d %b i %b data %h want 1 0 aaaa5555", d_resp, i_resp, d_rdata);
    else pass_count++;
    d_read = 1'b0;
    tick();
    check_count++;
    if (pmem_read !== 1'b0 || d_resp !== 1'b0)
      $display("FAIL conflict_bubble: got read %b d_resp %b want 0 0", pmem_read, d_resp);
    else pass_count++;
    tick();
    check_count++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h104)
      $display("FAIL conflict_fetch_second: got read %b addr %h want 1 00000104", pmem_read, pmem_address);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'h12345678;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== 32'h12345678 || d_rdata !== 32'hAAAA5555)
      $display("FAIL conflict_i_resp: got i %b d %b idata %h ddata %h want 1 0 12345678 aaaa5555",
               i_resp, d_resp, i_rdata, d_rdata);
    else pass_count++;
    i_read = 1'b0;
    tick();
  endtask

  task automatic test_store();
    d_write = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    tick();
    check_count++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h2004 ||
        pmem_wdata !== 32'hDEADBEEF || pmem_byte_enable !== 4'b0011)
      $display("FAIL store_issue: got w %b r %b addr %h data %h be %b want 1 0 00002004 deadbeef 0011",
               pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_byte_enable);
    else pass_count++;
    d_addr = 32'hFFFF0000; d_wdata = 32'h0; d_byte_enable = 4'b1111;
    tick();
    check_count++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h2004 ||
        pmem_wdata !== 32'hDEADBEEF || pmem_byte_enable !== 4'b0011)
      $display("FAIL store_hold: got w %b addr %h data %h be %b want 1 00002004 deadbeef 0011",
               pmem_write, pmem_address, pmem_wdata, pmem_byte_enable);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'hBADBAD00;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (d_resp !== 1'b1 || pmem_write !== 1'b0 || d_rdata !== 32'hAAAA5555)
      $display("FAIL store_resp: got resp %b w %b rdata %h want 1 0 aaaa5555", d_resp, pmem_write, d_rdata);
    else pass_count++;
    d_write = 1'b0;
    tick();
    check_count++;
    if (d_resp !== 1'b0)
      $display("FAIL store_pulse_end: got %b want 0", d_resp);
    else pass_count++;
  endtask

  task automatic test_dropped();
    i_read = 1'b1; i_addr = 32'h200;
    tick();
    check_count++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h200)
      $display("FAIL drop_issue: got read %b addr %h want 1 00000200", pmem_read, pmem_address);
    else pass_count++;
    i_read = 1'b0;
    tick();
    check_count++;
    if (pmem_read !== 1'b1)
      $display("FAIL drop_still_busy: got read %b want 1", pmem_read);
    else pass_count++;
    pmem_resp = 1'b1; pmem_rdata = 32'h77777777;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (i_resp !== 1'b0 || i_rdata !== 32'h12345678 || pmem_read !== 1'b0)
      $display("FAIL drop_suppressed: got resp %b data %h read %b want 0 12345678 0", i_resp, i_rdata, pmem_read);
    else pass_count++;
    tick();
    check_count++;
    if (i_resp !== 1'b0 || i_rdata !== 32'h12345678)
      $display("FAIL drop_after: got resp %b data %h want 0 12345678", i_resp, i_rdata);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    d_write = 1'b1; d_addr = 32'h3000; d_wdata = 32'h1; d_byte_enable = 4'b1111;
    tick();
    check_count++;
    if (pmem_write !== 1'b1)
      $display("FAIL rstmid_busy: got write %b want 1", pmem_write);
    else pass_count++;
    #2 rst = 1'b1;
    #1;
    check_count++;
    if (pmem_write !== 1'b0 || pmem_address !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL rstmid_async: got write %b addr %h rdata %h want 0 0 0", pmem_write, pmem_address, d_rdata);
    else pass_count++;
    tick();
    rst = 1'b0; d_write = 1'b0;
    tick();
    pmem_resp = 1'b1; pmem_rdata = 32'h5A5A5A5A;
    tick();
    pmem_resp = 1'b0;
    check_count++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || pmem_write !== 1'b0 || pmem_read !== 1'b0)
      $display("FAIL rstmid_late_resp: got d %b i %b w %b r %b want 0 0 0 0", d_resp, i_resp, pmem_write, pmem_read);
    else pass_count++;
    tick();
    check_count++;
    if (d_resp !== 1'b0 || d_rdata !== 32'h0)
      $display("FAIL rstmid_after: got resp %b rdata %h want 0 0", d_resp, d_rdata);
    else pass_count++;
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byte_enable = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_store();
    test_dropped();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that sits directly downstream of the pipelined datapath's memory ports. It merges the instruction-fetch port (IF stage) and the data port (MEM stage) onto one physical memory port. Each transaction is registered and held until the memory acknowledges it. The response is returned to the winning requester as a one-cycle pulse with registered read data. Data requests take priority because they belong to the older instruction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enable width is DATA_W/8)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- i_read  in  1  instruction fetch request (level, held until i_resp)
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid when i_resp=1
- i_resp  out  1  one-cycle fetch completion pulse
- d_read  in  1  data load request (level)
- d_write  in  1  data store request (level; d_read and d_write never both 1)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_byte_enable  in  DATA_W/8  store byte mask
- d_rdata  out  DATA_W  load data, valid when d_resp=1
- d_resp  out  1  one-cycle data completion pulse
- pmem_read  out  1  physical read strobe (level, held until pmem_resp)
- pmem_write  out  1  physical write strobe (level)
- pmem_address  out  ADDR_W  physical address
- pmem_wdata  out  DATA_W  physical write data
- pmem_byte_enable  out  DATA_W/8  physical byte mask
- pmem_rdata  in  DATA_W  physical read data, valid with pmem_resp
- pmem_resp  in  1  one-cycle physical completion pulse

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE:
  - (d_read|d_write)=1: latch d_addr, d_wdata, d_byte_enable and the read/write kind; go to D_BUSY.
  - Otherwise, i_read=1: latch i_addr; go to I_BUSY.
  - Otherwise, stay in IDLE.
- I_BUSY / D_BUSY:
  - pmem_* outputs are driven from the latched registers and stay constant until pmem_resp.
  - On pmem_resp, capture pmem_rdata into the winner's rdata register, assert the winner's resp on the next cycle, and go to RESP.
- RESP: the resp pulse is high for exactly this state; then go to IDLE unconditionally. No arbitration happens in RESP.
- Writes: d_resp pulses as for reads; d_rdata keeps its previous value.
- Dropped request: if the requester deasserts its request while in *_BUSY, the physical transaction still completes. Its resp pulse is suppressed and its rdata register is not updated.
- Request inputs are sampled only in IDLE. Changes to addr/data while BUSY are ignored.
- i_rdata and d_rdata are registers. They hold their last value until the next completion for that port.

## Timing
- Reset values: state=IDLE; all pmem strobes, i_resp and d_resp = 0; pmem_address, pmem_wdata, pmem_byte_enable, i_rdata, d_rdata = 0.
- Request visible in IDLE at cycle t → pmem strobe high at cycle t+1.
- pmem_resp at cycle c → pmem strobe low at c+1, and resp pulse + rdata valid at c+1 (RESP state).
- Back in IDLE at c+2, where a new request may be granted. Minimum occupancy is 3 cycles plus memory latency; there is one bubble cycle between transactions.
- Simultaneous i_read and d_read/d_write in IDLE: data wins. The fetch waits and is granted in the IDLE cycle after the data RESP, provided no new data request is present then.
- pmem_resp arriving in IDLE or RESP is ignored.
- rst asserted mid-transaction: immediately returns to IDLE with reset values. The physical transaction is abandoned and no resp pulse is issued.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- The arb_state_t enum (IDLE, I_BUSY, D_BUSY, RESP) lives in the shared rv32i_types package. Widths come from the parameters.
- One always_ff for the state register and latched request fields; one always_comb for next-state logic.
- No sub-module; the block is small enough to be flat.

## Test plan
- Reset: hold rst=1 with i_read=1. All outputs are 0 and state=IDLE. Release rst with i_read=1 and i_addr=0x60 → pmem_read=1 and pmem_address=0x60 one cycle later.
- Single fetch: i_read=1, i_addr=0x100; memory answers with pmem_resp and pmem_rdata=0x00000013 after 3 cycles. Expect i_rdata=0x00000013 and i_resp high for exactly 1 cycle, 1 cycle after pmem_resp.
- Conflict: i_read=1 (0x104) and d_read=1 (0x2000) in the same cycle. Expect pmem_address=0x2000 first and d_resp first; after the RESP bubble, pmem_address=0x104 and then i_resp.
- Store: d_write=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_byte_enable=4'b0011. Expect pmem_write=1 with identical address, data and mask held stable until pmem_resp; expect d_resp 1 cycle after pmem_resp; d_rdata unchanged.
- Dropped request: deassert i_read mid-transaction. The pmem transaction still completes, i_resp stays 0, and i_rdata keeps its old value.
- Reset mid-operation: assert rst during D_BUSY. pmem_write drops immediately, no d_resp is issued, and a later pmem_resp is ignored.
